// File: rtl/uart_fifo_param.sv
// Buffered UART: TX/RX FIFOs, run-time baud divider, parity and stop-bit modes,
// false-start rejection and sticky parity/framing/overflow error flags.
module uart_fifo_param #(
    parameter int DATA_BITS = 8,
    parameter int NUM_SYNC  = 5,
    parameter int TX_DEPTH  = 4,
    parameter int RX_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 rx_in,
    output logic                 tx_out,
    input  logic                 tx_latch,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    input  logic                 err_clear,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overflow
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_ERROR} rx_state_t;

    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

    function automatic logic par_bit(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    function automatic logic par_en(input logic [1:0] m);
        return (m == 2'b01) || (m == 2'b10);
    endfunction

    // rx_in synchroniser, idles high
    logic [NUM_SYNC-1:0] sync_q;
    logic                rx_s;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[NUM_SYNC-2:0], rx_in};
    end
    assign rx_s = sync_q[NUM_SYNC-1];

    // TX FIFO
    logic [DATA_BITS-1:0] txm [TX_DEPTH];
    logic [TAW:0]         txw_q, txr_q;
    logic                 tx_push, tx_pop, tx_fifo_empty;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_fifo_empty = (txw_q == txr_q);
    assign tx_full       = (txw_q[TAW] != txr_q[TAW]) && (txw_q[TAW-1:0] == txr_q[TAW-1:0]);
    assign tx_push       = tx_latch && !tx_full;
    assign tx_head       = txm[txr_q[TAW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            txw_q <= '0;
            txr_q <= '0;
        end else begin
            if (tx_push) txw_q <= txw_q + 1'b1;
            if (tx_pop)  txr_q <= txr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) txm[txw_q[TAW-1:0]] <= tx_data;
    end

    // TX FSM
    tx_state_t            txs_q, txs_d;
    logic [15:0]          txcnt_q, txcnt_d, txdiv_q, txdiv_d;
    logic [BW-1:0]        txbit_q, txbit_d;
    logic [DATA_BITS-1:0] txsh_q, txsh_d;
    logic                 txpen_q, txpen_d, txpar_q, txpar_d, tx2_q, tx2_d;
    logic                 txstop_q, txstop_d, txo_q, txo_d;
    logic                 tx_load, tx_bit_end;

    assign tx_bit_end = (txcnt_q == txdiv_q - 16'd1);

    always_comb begin
        txs_d    = txs_q;
        txcnt_d  = txcnt_q + 16'd1;
        txdiv_d  = txdiv_q;
        txbit_d  = txbit_q;
        txsh_d   = txsh_q;
        txpen_d  = txpen_q;
        txpar_d  = txpar_q;
        tx2_d    = tx2_q;
        txstop_d = txstop_q;
        txo_d    = txo_q;
        tx_load  = 1'b0;
        tx_pop   = 1'b0;
        case (txs_q)
            TX_IDLE: begin
                txcnt_d = '0;
                if (!tx_fifo_empty) tx_load = 1'b1;
            end
            TX_START: if (tx_bit_end) begin
                txs_d   = TX_DATA;
                txcnt_d = '0;
                txbit_d = '0;
                txo_d   = txsh_q[0];
            end
            TX_DATA: if (tx_bit_end) begin
                txcnt_d = '0;
                if (txbit_q == LAST_BIT) begin
                    txstop_d = 1'b0;
                    if (txpen_q) begin
                        txs_d = TX_PARITY;
                        txo_d = txpar_q;
                    end else begin
                        txs_d = TX_STOP;
                        txo_d = 1'b1;
                    end
                end else begin
                    txsh_d  = txsh_q >> 1;
                    txo_d   = txsh_q[1];
                    txbit_d = txbit_q + 1'b1;
                end
            end
            TX_PARITY: if (tx_bit_end) begin
                txs_d   = TX_STOP;
                txcnt_d = '0;
                txo_d   = 1'b1;
            end
            TX_STOP: if (tx_bit_end) begin
                txcnt_d = '0;
                if (tx2_q && !txstop_q) txstop_d = 1'b1;
                else if (!tx_fifo_empty) tx_load = 1'b1;
                else txs_d = TX_IDLE;
            end
            default: txs_d = TX_IDLE;
        endcase
        // Frame start: config is captured here so mid-frame changes wait a frame
        if (tx_load) begin
            tx_pop  = 1'b1;
            txs_d   = TX_START;
            txcnt_d = '0;
            txo_d   = 1'b0;
            txsh_d  = tx_head;
            txdiv_d = eff_div(baud_div);
            txpen_d = par_en(parity_mode);
            txpar_d = par_bit(tx_head, parity_mode[1]);
            tx2_d   = two_stop;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            txs_q    <= TX_IDLE;
            txcnt_q  <= '0;
            txbit_q  <= '0;
            txstop_q <= 1'b0;
            txo_q    <= 1'b1;
        end else begin
            txs_q    <= txs_d;
            txcnt_q  <= txcnt_d;
            txbit_q  <= txbit_d;
            txstop_q <= txstop_d;
            txo_q    <= txo_d;
        end
        txdiv_q <= txdiv_d;
        txsh_q  <= txsh_d;
        txpen_q <= txpen_d;
        txpar_q <= txpar_d;
        tx2_q   <= tx2_d;
    end

    assign tx_out   = txo_q;
    assign tx_empty = tx_fifo_empty && (txs_q == TX_IDLE);

    // RX FSM
    rx_state_t            rxs_q, rxs_d;
    logic [15:0]          rxcnt_q, rxcnt_d, rxdiv_q, rxdiv_d;
    logic [BW-1:0]        rxbit_q, rxbit_d;
    logic [DATA_BITS-1:0] rxsh_q, rxsh_d;
    logic                 rxpen_q, rxpen_d, rxodd_q, rxodd_d, rxpar_q, rxpar_d;
    logic                 rx_sample, rx_push_req, set_par, set_frm;

    assign rx_sample = (rxcnt_q == rxdiv_q);

    always_comb begin
        rxs_d       = rxs_q;
        rxcnt_d     = rxcnt_q + 16'd1;
        rxdiv_d     = rxdiv_q;
        rxbit_d     = rxbit_q;
        rxsh_d      = rxsh_q;
        rxpen_d     = rxpen_q;
        rxodd_d     = rxodd_q;
        rxpar_d     = rxpar_q;
        rx_push_req = 1'b0;
        set_par     = 1'b0;
        set_frm     = 1'b0;
        case (rxs_q)
            RX_IDLE: begin
                rxcnt_d = 16'd1;
                if (!rx_s) begin
                    rxs_d   = RX_START;
                    rxdiv_d = eff_div(baud_div);
                    rxpen_d = par_en(parity_mode);
                    rxodd_d = (parity_mode == 2'b10);
                end
            end
            RX_START: if (rxcnt_q == (rxdiv_q >> 1)) begin
                rxcnt_d = 16'd1;
                rxbit_d = '0;
                rxs_d   = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_sample) begin
                rxcnt_d = 16'd1;
                rxsh_d  = {rx_s, rxsh_q[DATA_BITS-1:1]};
                if (rxbit_q == LAST_BIT) rxs_d = rxpen_q ? RX_PARITY : RX_STOP;
                else rxbit_d = rxbit_q + 1'b1;
            end
            RX_PARITY: if (rx_sample) begin
                rxcnt_d = 16'd1;
                rxpar_d = rx_s;
                rxs_d   = RX_STOP;
            end
            RX_STOP: if (rx_sample) begin
                rxcnt_d = 16'd1;
                if (!rx_s) begin
                    set_frm = 1'b1;
                    rxs_d   = RX_ERROR;
                end else begin
                    rxs_d = RX_IDLE;
                    if (rxpen_q && (rxpar_q != par_bit(rxsh_q, rxodd_q))) set_par = 1'b1;
                    else rx_push_req = 1'b1;
                end
            end
            // A broken frame leaves the line low; wait for it to recover
            RX_ERROR: begin
                rxcnt_d = 16'd1;
                if (rx_s) rxs_d = RX_IDLE;
            end
            default: rxs_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxs_q   <= RX_IDLE;
            rxcnt_q <= '0;
            rxbit_q <= '0;
        end else begin
            rxs_q   <= rxs_d;
            rxcnt_q <= rxcnt_d;
            rxbit_q <= rxbit_d;
        end
        rxdiv_q <= rxdiv_d;
        rxsh_q  <= rxsh_d;
        rxpen_q <= rxpen_d;
        rxodd_q <= rxodd_d;
        rxpar_q <= rxpar_d;
    end

    // RX FIFO: a same-cycle pop frees room for a push into a full FIFO
    logic [DATA_BITS-1:0] rxm [RX_DEPTH];
    logic [RAW:0]         rxw_q, rxr_q;
    logic                 rx_fifo_empty, rx_fifo_full, rx_pop, rx_push, set_ovf;

    assign rx_fifo_empty = (rxw_q == rxr_q);
    assign rx_fifo_full  = (rxw_q[RAW] != rxr_q[RAW]) && (rxw_q[RAW-1:0] == rxr_q[RAW-1:0]);
    assign rx_pop        = rx_ack && !rx_fifo_empty;
    assign rx_push       = rx_push_req && (!rx_fifo_full || rx_pop);
    assign set_ovf       = rx_push_req && !rx_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxw_q <= '0;
            rxr_q <= '0;
        end else begin
            if (rx_push) rxw_q <= rxw_q + 1'b1;
            if (rx_pop)  rxr_q <= rxr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rxm[rxw_q[RAW-1:0]] <= rxsh_q;
    end

    assign rx_valid = !rx_fifo_empty;
    assign rx_data  = rx_fifo_empty ? '0 : rxm[rxr_q[RAW-1:0]];

    // Sticky error flags; a new event beats a simultaneous clear
    logic par_err_q, frm_err_q, ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            par_err_q <= (par_err_q && !err_clear) || set_par;
            frm_err_q <= (frm_err_q && !err_clear) || set_frm;
            ovf_q     <= (ovf_q && !err_clear) || set_ovf;
        end
    end

    assign rx_parity_err = par_err_q;
    assign rx_frame_err  = frm_err_q;
    assign rx_overflow   = ovf_q;
endmodule

// File: tb/tb_uart_fifo_param.sv
// Scoreboard bench for uart_fifo_param: TX waveform, loopback, RX error paths, reset.
module tb_uart_fifo_param;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] baud_div = 16'd16;
    logic [1:0]  parity_mode = 2'b00;
    logic        two_stop = 1'b0;
    logic        rx_in;
    logic        tx_out;
    logic        tx_latch = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_full, tx_empty;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack = 1'b0;
    logic        err_clear = 1'b0;
    logic        rx_parity_err, rx_frame_err, rx_overflow;
    logic        loop = 1'b0;
    logic        rx_drv = 1'b1;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic       exp_bits[$];

    assign rx_in = loop ? tx_out : rx_drv;

    uart_fifo_param #(.DATA_BITS(8), .NUM_SYNC(5), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .baud_div(baud_div), .parity_mode(parity_mode),
        .two_stop(two_stop), .rx_in(rx_in), .tx_out(tx_out), .tx_latch(tx_latch),
        .tx_data(tx_data), .tx_full(tx_full), .tx_empty(tx_empty), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ack(rx_ack), .err_clear(err_clear),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overflow(rx_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input int budget, output bit ok);
        int n = 0;
        while (!rx_valid && n < budget) begin
            tick(1);
            n++;
        end
        ok = rx_valid;
    endtask

    task automatic wait_tx_idle(input int budget, output bit ok);
        int n = 0;
        while (!tx_empty && n < budget) begin
            tick(1);
            n++;
        end
        ok = tx_empty;
    endtask

    task automatic send_frame(input logic [7:0] d, input int div, input bit pen,
                              input logic pbit, input logic stop);
        rx_drv = 1'b0;
        tick(div);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            tick(div);
        end
        if (pen) begin
            rx_drv = pbit;
            tick(div);
        end
        rx_drv = stop;
        tick(div);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        for (int pass = 0; pass < 2; pass++) begin
            checks++;
            if (tx_out !== 1'b1 || tx_full !== 1'b0 || tx_empty !== 1'b1) begin
                failures++;
                $display("FAIL reset_tx pass%0d out=%b full=%b empty=%b required 1 0 1",
                         pass, tx_out, tx_full, tx_empty);
            end
            checks++;
            if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
                failures++;
                $display("FAIL reset_rx pass%0d valid=%b data=%h required 0 00", pass, rx_valid, rx_data);
            end
            checks++;
            if ({rx_parity_err, rx_frame_err, rx_overflow} !== 3'b000) begin
                failures++;
                $display("FAIL reset_flags pass%0d flags=%b required 000",
                         pass, {rx_parity_err, rx_frame_err, rx_overflow});
            end
            reset = 1'b0;
            tick(2);
        end
    endtask

    task automatic test_tx_frame;
        logic [7:0] d = 8'hA5;
        logic       e;
        bit         ok;
        baud_div = 16'd16; parity_mode = 2'b00; two_stop = 1'b0;
        exp_bits.delete();
        tx_data = d; tx_latch = 1'b1;
        tick(1);
        tx_latch = 1'b0;
        checks++;
        if (tx_out !== 1'b1 || tx_empty !== 1'b0) begin
            failures++;
            $display("FAIL tx_latency_n1 out=%b empty=%b required 1 0", tx_out, tx_empty);
        end
        tick(1);
        checks++;
        if (tx_out !== 1'b0) begin
            failures++;
            $display("FAIL tx_latency_n2 out=%b required 0", tx_out);
        end
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        exp_bits.push_back(1'b1);
        tick(8);
        for (int i = 0; i < 10; i++) begin
            e = exp_bits.pop_front();
            checks++;
            if (tx_out !== e) begin
                failures++;
                $display("FAIL tx_bit%0d out=%b required %b", i, tx_out, e);
            end
            tick(16);
        end
        wait_tx_idle(20, ok);
        checks++;
        if (!ok || tx_out !== 1'b1) begin
            failures++;
            $display("FAIL tx_idle_after empty=%b out=%b required 1 1", tx_empty, tx_out);
        end
    endtask

    task automatic test_loopback_back_to_back;
        logic [7:0] words[4] = '{8'h00, 8'hFF, 8'h3C, 8'h07};
        logic [7:0] e;
        bit         ok;
        baud_div = 16'd16; parity_mode = 2'b01; two_stop = 1'b1;
        exp_q.delete();
        loop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data = words[i]; tx_latch = 1'b1;
            exp_q.push_back(words[i]);
            tick(1);
        end
        tx_latch = 1'b0;
        wait_tx_idle(2000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL lb_tx_drain tx_empty=%b required 1", tx_empty);
        end
        tick(30);
        for (int k = 0; k < 4; k++) begin
            wait_rx(50, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL lb_word%0d rx_valid=%b required 1", k, rx_valid);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (rx_data !== e) begin
                    failures++;
                    $display("FAIL lb_data%0d rx_data=%h required %h", k, rx_data, e);
                end
                rx_ack = 1'b1;
                tick(1);
                rx_ack = 1'b0;
            end
        end
        checks++;
        if (rx_valid !== 1'b0 || {rx_parity_err, rx_frame_err, rx_overflow} !== 3'b000) begin
            failures++;
            $display("FAIL lb_after valid=%b flags=%b required 0 000",
                     rx_valid, {rx_parity_err, rx_frame_err, rx_overflow});
        end
        loop = 1'b0;
        two_stop = 1'b0;
        tick(5);
    endtask

    task automatic test_false_start;
        logic [7:0] e;
        bit         ok;
        baud_div = 16'd16; parity_mode = 2'b00;
        exp_q.delete();
        rx_drv = 1'b0;
        tick(5);
        rx_drv = 1'b1;
        tick(40);
        checks++;
        if (rx_valid !== 1'b0 || {rx_parity_err, rx_frame_err, rx_overflow} !== 3'b000) begin
            failures++;
            $display("FAIL false_start valid=%b flags=%b required 0 000",
                     rx_valid, {rx_parity_err, rx_frame_err, rx_overflow});
        end
        // A normal frame right after shows the receiver went back to idle
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b1);
        wait_rx(20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL false_start_recover rx_valid=%b required 1", rx_valid);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (rx_data !== e) begin
                failures++;
                $display("FAIL false_start_data rx_data=%h required %h", rx_data, e);
            end
            rx_ack = 1'b1;
            tick(1);
            rx_ack = 1'b0;
        end
    endtask

    task automatic test_parity_error;
        logic [7:0] e;
        bit         ok;
        baud_div = 16'd16; parity_mode = 2'b10;
        exp_q.delete();
        // 0x01 holds one set bit, so odd parity needs a 0; a 1 is the corrupt case
        send_frame(8'h01, 16, 1'b1, 1'b1, 1'b1);
        tick(4);
        checks++;
        if (rx_parity_err !== 1'b1 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL parity_err perr=%b valid=%b required 1 0", rx_parity_err, rx_valid);
        end
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        checks++;
        if (rx_parity_err !== 1'b0) begin
            failures++;
            $display("FAIL parity_clear perr=%b required 0", rx_parity_err);
        end
        exp_q.push_back(8'h01);
        send_frame(8'h01, 16, 1'b1, 1'b0, 1'b1);
        wait_rx(20, ok);
        checks++;
        if (!ok || rx_parity_err !== 1'b0) begin
            failures++;
            $display("FAIL parity_good valid=%b perr=%b required 1 0", rx_valid, rx_parity_err);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (rx_data !== e) begin
                failures++;
                $display("FAIL parity_good_data rx_data=%h required %h", rx_data, e);
            end
            rx_ack = 1'b1;
            tick(1);
            rx_ack = 1'b0;
        end
    endtask

    task automatic test_overflow;
        logic [7:0] words[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h77};
        logic [7:0] e;
        bit         ok;
        baud_div = 16'd16; parity_mode = 2'b00;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(words[i]);
            send_frame(words[i], 16, 1'b0, 1'b0, 1'b1);
            tick(2);
            if (i == 3) begin
                checks++;
                if (rx_overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_early ovf=%b required 0", rx_overflow);
                end
            end
        end
        tick(4);
        checks++;
        if (rx_overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag ovf=%b required 1", rx_overflow);
        end
        for (int k = 0; k < 4; k++) begin
            wait_rx(5, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL ovf_word%0d rx_valid=%b required 1", k, rx_valid);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (rx_data !== e) begin
                    failures++;
                    $display("FAIL ovf_data%0d rx_data=%h required %h", k, rx_data, e);
                end
                rx_ack = 1'b1;
                tick(1);
                rx_ack = 1'b0;
            end
        end
        checks++;
        if (rx_valid !== 1'b0 || rx_overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_after valid=%b ovf=%b required 0 1", rx_valid, rx_overflow);
        end
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        checks++;
        if (rx_overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear ovf=%b required 0", rx_overflow);
        end
    endtask

    task automatic test_frame_error;
        logic [7:0] e;
        bit         ok;
        baud_div = 16'd16; parity_mode = 2'b00;
        exp_q.delete();
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0);
        tick(40);
        checks++;
        if (rx_frame_err !== 1'b1 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL frame_err ferr=%b valid=%b required 1 0", rx_frame_err, rx_valid);
        end
        rx_drv = 1'b1;
        tick(40);
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL frame_hold_push valid=%b required 0", rx_valid);
        end
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1);
        wait_rx(20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL frame_recover rx_valid=%b required 1", rx_valid);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (rx_data !== e) begin
                failures++;
                $display("FAIL frame_recover_data rx_data=%h required %h", rx_data, e);
            end
            rx_ack = 1'b1;
            tick(1);
            rx_ack = 1'b0;
        end
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        checks++;
        if (rx_frame_err !== 1'b0) begin
            failures++;
            $display("FAIL frame_clear ferr=%b required 0", rx_frame_err);
        end
    endtask

    task automatic test_reset_mid_tx;
        baud_div = 16'd16; parity_mode = 2'b00; two_stop = 1'b0;
        tx_data = 8'hA5; tx_latch = 1'b1;
        tick(1);
        for (int i = 1; i <= 4; i++) begin
            tx_data = 8'(i);
            tick(1);
        end
        tx_latch = 1'b0;
        checks++;
        if (tx_full !== 1'b1) begin
            failures++;
            $display("FAIL mid_full tx_full=%b required 1", tx_full);
        end
        // Now 3 clocks into the start bit; move to the middle of data bit 1 (a 0 for 0xA5)
        tick(37);
        checks++;
        if (tx_out !== 1'b0) begin
            failures++;
            $display("FAIL mid_databit tx_out=%b required 0", tx_out);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (tx_out !== 1'b1 || tx_empty !== 1'b1 || tx_full !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset out=%b empty=%b full=%b required 1 1 0",
                     tx_out, tx_empty, tx_full);
        end
        reset = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback_back_to_back();
        test_false_start();
        test_parity_error();
        test_overflow();
        test_frame_error();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
